// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Holds the state enum, opcode constants, datapath mux encodings and the
// instruction-class struct produced by multicycle_opclass.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One-hot instruction class; all-zero means the opcode is not decodable.
  typedef struct packed {
    logic lw;
    logic sw;
    logic rtype;
    logic addi;
    logic andi;
    logic beq;
    logic bne;
    logic j;
  } opclass_t;

endpackage

// File: rtl/multicycle_opclass.sv
// Opcode classifier for the multi-cycle control FSM.
// Ports:
//   i_opcode  - IR[31:26]
//   o_cls     - one-hot instruction class
//   o_illegal - opcode matches no supported instruction
module multicycle_opclass
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output opclass_t   o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls = '0;
    case (i_opcode)
      OP_LW:    o_cls.lw    = 1'b1;
      OP_SW:    o_cls.sw    = 1'b1;
      OP_RTYPE: o_cls.rtype = 1'b1;
      OP_ADDI:  o_cls.addi  = 1'b1;
      OP_ANDI:  o_cls.andi  = 1'b1;
      OP_BEQ:   o_cls.beq   = 1'b1;
      OP_BNE:   o_cls.bne   = 1'b1;
      OP_J:     o_cls.j     = 1'b1;
      default:  o_cls       = '0;
    endcase
  end

  assign o_illegal = ~|o_cls;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Ports:
//   i_clk, i_rst_n         - clock, async active-low reset
//   i_opcode, i_zero       - IR opcode, ALU zero flag
//   i_mem_ready            - memory access completes this cycle
//   o_PCWrite .. o_ExtOp   - datapath strobes and mux selects
//   o_Retire, o_IllegalOp  - per-instruction status pulses
//   o_State                - current state, for debug
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4 into PC on mem_ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | A + imm into ALUOut
// MEM_READ  | load from ALUOut, wait for mem_ready
// MEM_WB    | MDR into rt
// MEM_WRITE | store B to ALUOut, wait for mem_ready
// R_EXEC    | A funct B
// R_WB      | ALUOut into rd
// I_EXEC    | A op imm (add or and with zero-extend)
// I_WB      | ALUOut into rt
// BRANCH    | compare A-B, conditional PC load from ALUOut
// JUMP      | PC load from jump target
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_PCWrite,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_IRWrite,
  output logic       o_MemtoReg,
  output logic       o_RegDst,
  output logic       o_RegWrite,
  output logic       o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_PCSource,
  output logic       o_ExtOp,
  output logic       o_Retire,
  output logic       o_IllegalOp,
  output logic [3:0] o_State
);

  state_t   r_state;
  state_t   w_nxt;
  opclass_t w_cls;
  logic     w_illegal;

  multicycle_opclass u_opclass (
    .i_opcode  (i_opcode),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_nxt;
  end

  assign o_State = r_state;

  // Strobes are gated by i_rst_n directly so that asserting reset kills any
  // in-flight write or status pulse within the same cycle.
  always_comb begin
    w_nxt       = S_FETCH;
    o_PCWrite   = 1'b0;
    o_IorD      = 1'b0;
    o_MemRead   = 1'b0;
    o_MemWrite  = 1'b0;
    o_IRWrite   = 1'b0;
    o_MemtoReg  = 1'b0;
    o_RegDst    = 1'b0;
    o_RegWrite  = 1'b0;
    o_ALUSrcA   = 1'b0;
    o_ALUSrcB   = SRCB_REG;
    o_ALUOp     = ALUOP_ADD;
    o_PCSource  = PCSRC_ALU;
    o_ExtOp     = 1'b0;
    o_Retire    = 1'b0;
    o_IllegalOp = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        S_FETCH: begin
          o_MemRead = 1'b1;
          o_ALUSrcB = SRCB_FOUR;
          o_IRWrite = i_mem_ready;
          o_PCWrite = i_mem_ready;
          w_nxt     = i_mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          o_ALUSrcB = SRCB_BOFF;
          if (w_cls.lw || w_cls.sw)        w_nxt = S_MEM_ADDR;
          else if (w_cls.rtype)            w_nxt = S_R_EXEC;
          else if (w_cls.addi || w_cls.andi) w_nxt = S_I_EXEC;
          else if (w_cls.beq || w_cls.bne) w_nxt = S_BRANCH;
          else if (w_cls.j)                w_nxt = S_JUMP;
          else begin
            o_IllegalOp = w_illegal;
            w_nxt       = S_FETCH;
          end
        end
        S_MEM_ADDR: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = SRCB_IMM;
          w_nxt     = w_cls.sw ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          o_MemRead = 1'b1;
          o_IorD    = 1'b1;
          w_nxt     = i_mem_ready ? S_MEM_WB : S_MEM_READ;
        end
        S_MEM_WB: begin
          o_RegWrite = 1'b1;
          o_MemtoReg = 1'b1;
          o_Retire   = 1'b1;
        end
        S_MEM_WRITE: begin
          o_MemWrite = 1'b1;
          o_IorD     = 1'b1;
          o_Retire   = i_mem_ready;
          w_nxt      = i_mem_ready ? S_FETCH : S_MEM_WRITE;
        end
        S_R_EXEC: begin
          o_ALUSrcA = 1'b1;
          o_ALUOp   = ALUOP_FUNCT;
          w_nxt     = S_R_WB;
        end
        S_R_WB: begin
          o_RegWrite = 1'b1;
          o_RegDst   = 1'b1;
          o_Retire   = 1'b1;
        end
        S_I_EXEC: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = SRCB_IMM;
          if (w_cls.andi) begin
            o_ALUOp = ALUOP_AND;
            o_ExtOp = 1'b1;
          end
          w_nxt = S_I_WB;
        end
        S_I_WB: begin
          o_RegWrite = 1'b1;
          o_Retire   = 1'b1;
        end
        S_BRANCH: begin
          o_ALUSrcA  = 1'b1;
          o_ALUOp    = ALUOP_SUB;
          o_PCSource = PCSRC_ALUOUT;
          o_PCWrite  = w_cls.bne ? ~i_zero : i_zero;
          o_Retire   = 1'b1;
        end
        S_JUMP: begin
          o_PCSource = PCSRC_JUMP;
          o_PCWrite  = 1'b1;
          o_Retire   = 1'b1;
        end
        default: w_nxt = S_FETCH;
      endcase
    end
  end

endmodule
